// File: rtl/cordic_iter_sched.sv
// Iterative rotation-mode CORDIC scheduler: one shared FP add/sub unit serves the x, y and z
// updates of each iteration; atan(2^-i) comes from an external combinational ROM.
module cordic_iter_sched #(
  parameter int unsigned N_ITER  = 16,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_angle,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_z,
  output logic [31:0] fas_in1,
  output logic [31:0] fas_in2,
  output logic        fas_en,
  input  logic [31:0] fas_out,
  output logic [4:0]  atan_idx,
  input  logic [31:0] atan_val
);

  typedef enum logic [2:0] {IDLE, ISS_X, ISS_Y, ISS_Z, WAIT, DONE} state_t;

  localparam logic [3:0] CAP_X = 4'(ADD_LAT);
  localparam logic [3:0] CAP_Y = 4'(ADD_LAT + 1);
  localparam logic [3:0] CAP_Z = 4'(ADD_LAT + 2);
  localparam logic [4:0] LAST  = 5'(N_ITER - 1);

  state_t      state, state_nx;
  logic [31:0] x, y, z, nx, ny;
  logic [4:0]  iter;
  logic        d;
  logic [3:0]  cnt;
  logic        busy;
  logic        issue;
  logic [31:0] in1_c, in2_c;
  logic        en_c;
  logic [31:0] hold1, hold2;
  logic        hold_en;

  // Multiply by 2^-k through the exponent; underflow flushes to signed zero.
  function automatic logic [31:0] sh(input logic [31:0] v, input logic [4:0] k);
    logic [7:0] e;
    e = v[30:23];
    if (e == 8'hFF) return v;
    else if (e <= {3'b000, k}) return {v[31], 31'b0};
    else return {v[31], e - {3'b000, k}, v[22:0]};
  endfunction

  assign busy      = (state == ISS_Y) || (state == ISS_Z) || (state == WAIT);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign atan_idx  = iter;
  assign fas_in1   = in1_c;
  assign fas_in2   = in2_c;
  assign fas_en    = en_c;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    in1_c    = hold1;
    in2_c    = hold2;
    en_c     = hold_en;
    case (state)
      IDLE:  if (in_valid) state_nx = ISS_X;
      ISS_X: begin
        issue    = 1'b1;
        in1_c    = x;
        in2_c    = sh(y, iter);
        en_c     = z[31];
        state_nx = ISS_Y;
      end
      ISS_Y: begin
        issue    = 1'b1;
        in1_c    = y;
        in2_c    = sh(x, iter);
        en_c     = ~d;
        state_nx = ISS_Z;
      end
      ISS_Z: begin
        issue    = 1'b1;
        in1_c    = z;
        in2_c    = atan_val;
        en_c     = d;
        state_nx = WAIT;
      end
      WAIT:  if (cnt == CAP_Z) state_nx = (iter == LAST) ? DONE : ISS_X;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      iter    <= '0;
      d       <= 1'b0;
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      nx      <= '0;
      ny      <= '0;
      out_x   <= '0;
      out_y   <= '0;
      out_z   <= '0;
      hold1   <= '0;
      hold2   <= '0;
      hold_en <= 1'b0;
    end else begin
      state <= state_nx;
      if (issue) begin
        hold1   <= in1_c;
        hold2   <= in2_c;
        hold_en <= en_c;
      end
      // cnt = cycles since this iteration's ISS_X; results land at fixed offsets
      if (state == ISS_X) cnt <= 4'd1;
      else if (busy) cnt <= cnt + 4'd1;
      if (busy && cnt == CAP_X) nx <= fas_out;
      if (busy && cnt == CAP_Y) ny <= fas_out;
      case (state)
        IDLE: if (in_valid) begin
          x    <= in_x;
          y    <= in_y;
          z    <= in_angle;
          iter <= '0;
        end
        ISS_X: d <= z[31];
        WAIT: if (cnt == CAP_Z) begin
          // z result is committed straight off the adder in its capture cycle
          x <= nx;
          y <= ny;
          z <= fas_out;
          if (iter == LAST) begin
            out_x <= nx;
            out_y <= ny;
            out_z <= fas_out;
          end else begin
            iter <= iter + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
